// File: rtl/ysyx_23060077_icache_dm.sv
// Direct-mapped, read-only instruction cache below the IFU.
// Hits answer in one cycle; misses refill a whole line over a read burst; fence.i flushes every line.
module ysyx_23060077_icache_dm #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifu_valid_i,
    input  logic [ADDR_WIDTH-1:0] ifu_addr_i,
    output logic                  ifu_ready_o,
    output logic [DATA_WIDTH-1:0] ifu_data_o,
    input  logic                  ifu_fence_i,
    output logic                  Icache_r_valid_o,
    output logic [ADDR_WIDTH-1:0] Icache_r_addr_o,
    output logic [LEN_WIDTH-1:0]  Icache_r_len_o,
    input  logic                  Icache_r_ready_i,
    input  logic [DATA_WIDTH-1:0] Icache_r_data_i,
    input  logic                  Icache_r_last_i
);
    localparam int OFF = $clog2(LINE_WORDS * 4);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = ADDR_WIDTH - IDX - OFF;
    localparam int WW  = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

    state_t                  state, state_nx;
    logic [SETS-1:0]         valid_q;
    logic [TAG-1:0]          tag_mem  [SETS];
    logic [DATA_WIDTH-1:0]   data_mem [SETS][LINE_WORDS];
    logic [ADDR_WIDTH-1:2]   req_addr;
    logic [WW-1:0]           beat_cnt;
    logic                    fence_d, fence_pend;

    logic [TAG-1:0]          req_tag;
    logic [IDX-1:0]          req_idx;
    logic [WW-1:0]           req_word;
    logic                    hit, flush, accept, beat_fire, refill_done, fence_rise;
    logic                    unused_addr_lsb;

    // Byte-lane bits of the fetch PC carry no information for word fetches.
    assign unused_addr_lsb = ^ifu_addr_i[1:0];

    assign req_tag     = req_addr[ADDR_WIDTH-1 -: TAG];
    assign req_idx     = req_addr[OFF +: IDX];
    assign req_word    = req_addr[2 +: WW];
    assign hit         = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign beat_fire   = (state == REFILL) && Icache_r_ready_i;
    assign refill_done = beat_fire && Icache_r_last_i;
    assign fence_rise  = ifu_fence_i && !fence_d;
    assign Icache_r_len_o = LEN_WIDTH'(LINE_WORDS - 1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx         = state;
        ifu_ready_o      = 1'b0;
        ifu_data_o       = '0;
        Icache_r_valid_o = 1'b0;
        Icache_r_addr_o  = '0;
        flush            = 1'b0;
        accept           = 1'b0;
        unique case (state)
            IDLE: begin
                if (fence_pend) begin
                    flush = 1'b1;
                end else if (ifu_valid_i) begin
                    accept   = 1'b1;
                    state_nx = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    ifu_ready_o = 1'b1;
                    ifu_data_o  = data_mem[req_idx][req_word];
                    state_nx    = IDLE;
                end else begin
                    state_nx = REFILL;
                end
            end
            REFILL: begin
                Icache_r_valid_o = 1'b1;
                Icache_r_addr_o  = {req_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                if (refill_done) state_nx = RESP;
            end
            RESP: begin
                ifu_ready_o = 1'b1;
                ifu_data_o  = data_mem[req_idx][req_word];
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q    <= '0;
            fence_d    <= 1'b0;
            fence_pend <= 1'b0;
            beat_cnt   <= '0;
            req_addr   <= '0;
        end else begin
            fence_d <= ifu_fence_i;
            // A new edge arriving on the flush cycle wins, so it earns a flush of its own.
            if (fence_rise) fence_pend <= 1'b1;
            else if (flush) fence_pend <= 1'b0;

            if (flush)            valid_q          <= '0;
            else if (refill_done) valid_q[req_idx] <= 1'b1;

            if (accept) req_addr <= ifu_addr_i[ADDR_WIDTH-1:2];

            if (state == LOOKUP) beat_cnt <= '0;
            else if (beat_fire)  beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // NOTE: tag/data arrays are not reset; valid_q alone decides whether their contents mean anything.
    always_ff @(posedge clock) begin
        if (beat_fire)   data_mem[req_idx][beat_cnt] <= Icache_r_data_i;
        if (refill_done) tag_mem[req_idx]            <= req_tag;
    end

endmodule
